instr_fetch: RTL and testbench

- Fetch sequencer on the writer side of the instruction register interface.
- On request from the control unit it:
  - reads one instruction word from program memory at the program counter,
  - presents that word on the IR data lines and pulses the IR write enable,
  - increments the PC.
- It owns the PC. The IR captures bits [11:0] as the operand/address and bits [16:12] as the opcode. This block only delivers the full word.

---
 rtl/instr_fetch_if.sv | 28 ++
 rtl/instr_fetch.sv | 78 +++++++
 tb/tb_instr_fetch.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Bundle between the fetch sequencer, the control unit, program memory and the IR.
// The master side is the fetch sequencer; the slave side is everything around it.
interface instr_fetch_if #(
  parameter int N      = 17,
  parameter int ADDR_W = 12
);
  logic              fetch_req;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_in;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [N-1:0]      mem_rdata;
  logic [N-1:0]      ir_data;
  logic              ir_write_en;
  logic              busy;
  logic              fetch_done;

  modport master (
    input  fetch_req, pc_load, pc_in, mem_rdata,
    output pc_out, mem_addr, mem_rd_en, ir_data, ir_write_en, busy, fetch_done
  );

  modport slave (
    output fetch_req, pc_load, pc_in, mem_rdata,
    input  pc_out, mem_addr, mem_rd_en, ir_data, ir_write_en, busy, fetch_done
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: owns the PC, reads one word per request from program
// memory and hands it to the IR with a single-cycle write strobe.
module instr_fetch #(
  parameter int N       = 17,
  parameter int ADDR_W  = 12,
  parameter int MEM_LAT = 2
) (
  input logic            clk,
  input logic            rst,
  instr_fetch_if.master  bus
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_CAPTURE,
    S_ISSUE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;
  logic [N-1:0]      ir_q;
  logic [CW-1:0]     wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Requests are only looked at in IDLE and ISSUE; mid-fetch requests are dropped.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (bus.fetch_req) state_next = S_ADDR;
      S_ADDR:    state_next = (MEM_LAT == 1) ? S_CAPTURE : S_WAIT;
      S_WAIT:    if (wait_cnt <= CW'(1)) state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_ISSUE;
      S_ISSUE:   state_next = bus.fetch_req ? S_ADDR : S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // The PC only moves in IDLE (jump) or ISSUE (increment, or jump which wins).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= '0;
      ir_q     <= '0;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE:    if (bus.pc_load) pc <= bus.pc_in;
        S_ADDR:    wait_cnt <= CW'(MEM_LAT - 1);
        S_WAIT:    wait_cnt <= wait_cnt - CW'(1);
        S_CAPTURE: ir_q <= bus.mem_rdata;
        S_ISSUE:   pc <= bus.pc_load ? bus.pc_in : pc + ADDR_W'(1);
        default:   ;
      endcase
    end
  end

  always_comb begin
    bus.mem_rd_en   = (state == S_ADDR);
    bus.ir_write_en = (state == S_ISSUE);
    bus.fetch_done  = (state == S_ISSUE);
    bus.busy        = (state != S_IDLE);
    bus.pc_out      = pc;
    bus.mem_addr    = pc;
    bus.ir_data     = ir_q;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: three instances (MEM_LAT 2, 1, 4) share the same stimulus and
// are each compared every cycle against a fetch-phase model, plus directed checks.
module tb_instr_fetch;

  localparam int N  = 17;
  localparam int AW = 12;

  logic          clk;
  logic          rst;
  logic          fetch_req;
  logic          pc_load;
  logic [AW-1:0] pc_in;
  logic [N-1:0]  mem [4096];
  logic [N-1:0]  junk;

  logic [AW-1:0] pc_out_a [3];
  logic [AW-1:0] addr_a   [3];
  logic          rd_a     [3];
  logic [N-1:0]  ir_a     [3];
  logic          we_a     [3];
  logic          busy_a   [3];
  logic          fd_a     [3];

  int total;
  int bad;

  int            m_phase [3];
  logic [AW-1:0] m_pc    [3];
  logic [N-1:0]  m_ir    [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) junk <= N'($urandom);

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    instr_fetch_if #(.N(N), .ADDR_W(AW)) bus ();
    logic [L-1:0]  pipe_v;
    logic [AW-1:0] pipe_a [L];

    instr_fetch #(.N(N), .ADDR_W(AW), .MEM_LAT(L)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.fetch_req = fetch_req;
    assign bus.pc_load   = pc_load;
    assign bus.pc_in     = pc_in;

    // Program memory: data for a read strobe is valid exactly L cycles later.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        pipe_v <= '0;
      end else begin
        pipe_v[0] <= bus.mem_rd_en;
        pipe_a[0] <= bus.mem_addr;
        for (int i = 1; i < L; i++) begin
          pipe_v[i] <= pipe_v[i-1];
          pipe_a[i] <= pipe_a[i-1];
        end
      end
    end
    assign bus.mem_rdata = pipe_v[L-1] ? mem[pipe_a[L-1]] : junk;

    assign pc_out_a[g] = bus.pc_out;
    assign addr_a[g]   = bus.mem_addr;
    assign rd_a[g]     = bus.mem_rd_en;
    assign ir_a[g]     = bus.ir_data;
    assign we_a[g]     = bus.ir_write_en;
    assign busy_a[g]   = bus.busy;
    assign fd_a[g]     = bus.fetch_done;
  end

  function automatic int latOf(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
  endfunction

  // Fetch phase: -1 idle, 0 = read strobe cycle, L = capture cycle, L+1 = IR write cycle.
  task automatic modelReset();
    for (int g = 0; g < 3; g++) begin
      m_phase[g] = -1;
      m_pc[g]    = '0;
      m_ir[g]    = '0;
    end
  endtask

  task automatic modelEdge(input logic req, input logic load, input logic [AW-1:0] target);
    for (int g = 0; g < 3; g++) begin
      if (m_phase[g] < 0) begin
        if (load) m_pc[g] = target;
        if (req) m_phase[g] = 0;
      end else if (m_phase[g] == latOf(g) + 1) begin
        m_pc[g]    = load ? target : m_pc[g] + 12'd1;
        m_phase[g] = req ? 0 : -1;
      end else begin
        if (m_phase[g] == latOf(g)) m_ir[g] = mem[m_pc[g]];
        m_phase[g] = m_phase[g] + 1;
      end
    end
  endtask

  task automatic checkOutput(input string name, input int g, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s inst%0d (lat %0d): got %0h want %0h", name, g, latOf(g), act, exp);
    end
  endtask

  task automatic checkAgainstModel();
    for (int g = 0; g < 3; g++) begin
      checkOutput("pc_out",      g, 32'(pc_out_a[g]), 32'(m_pc[g]));
      checkOutput("mem_addr",    g, 32'(addr_a[g]),   32'(m_pc[g]));
      checkOutput("mem_rd_en",   g, 32'(rd_a[g]),     32'(m_phase[g] == 0));
      checkOutput("ir_data",     g, 32'(ir_a[g]),     32'(m_ir[g]));
      checkOutput("ir_write_en", g, 32'(we_a[g]),     32'(m_phase[g] == latOf(g) + 1));
      checkOutput("fetch_done",  g, 32'(fd_a[g]),     32'(m_phase[g] == latOf(g) + 1));
      checkOutput("busy",        g, 32'(busy_a[g]),   32'(m_phase[g] >= 0));
    end
  endtask

  task automatic applyStimulus(input logic req, input logic load, input logic [AW-1:0] target);
    fetch_req = req;
    pc_load   = load;
    pc_in     = target;
    @(posedge clk);
    modelEdge(req, load, target);
    #1;
    checkAgainstModel();
  endtask

  task automatic idleSteps(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0);
  endtask

  typedef struct {
    logic          req;
    logic          load;
    logic [AW-1:0] target;
    logic          e_rd;
    logic          e_we;
    logic          e_busy;
    logic [AW-1:0] e_pc;
    logic [N-1:0]  e_ir;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int rd_cyc[$];
    logic [AW-1:0] rd_addr[$];
    int we_cnt;
    int rd_cnt;
    int first_we [3];
    int we_hits  [3];

    total = 0;
    bad   = 0;

    // Basic fetch, jump+fetch, and wrap-around, observed on the MEM_LAT=2 instance.
    vecs[0]  = '{1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 12'h000, 17'h00000};
    vecs[1]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h000, 17'h00000};
    vecs[2]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h000, 17'h00000};
    vecs[3]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 12'h000, 17'h12ABC};
    vecs[4]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h001, 17'h12ABC};
    vecs[5]  = '{1'b1, 1'b1, 12'h3F0, 1'b1, 1'b0, 1'b1, 12'h3F0, 17'h12ABC};
    vecs[6]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h3F0, 17'h12ABC};
    vecs[7]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h3F0, 17'h12ABC};
    vecs[8]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 12'h3F0, 17'h05A5A};
    vecs[9]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h3F1, 17'h05A5A};
    vecs[10] = '{1'b1, 1'b1, 12'hFFF, 1'b1, 1'b0, 1'b1, 12'hFFF, 17'h05A5A};
    vecs[11] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'hFFF, 17'h05A5A};
    vecs[12] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'hFFF, 17'h05A5A};
    vecs[13] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 12'hFFF, 17'h1F00F};
    vecs[14] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 17'h1F00F};

    for (int a = 0; a < 4096; a++) mem[a] = N'($urandom);
    mem[12'h000] = 17'h12ABC;
    mem[12'h3F0] = 17'h05A5A;
    mem[12'hFFF] = 17'h1F00F;

    rst       = 1'b1;
    fetch_req = 1'b0;
    pc_load   = 1'b0;
    pc_in     = '0;
    modelReset();
    #2;
    checkAgainstModel();
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 15; v++) begin
      applyStimulus(vecs[v].req, vecs[v].load, vecs[v].target);
      checkOutput($sformatf("vec%0d rd_en", v), 0, 32'(rd_a[0]), 32'(vecs[v].e_rd));
      checkOutput($sformatf("vec%0d we", v),    0, 32'(we_a[0]), 32'(vecs[v].e_we));
      checkOutput($sformatf("vec%0d done", v),  0, 32'(fd_a[0]), 32'(vecs[v].e_we));
      checkOutput($sformatf("vec%0d busy", v),  0, 32'(busy_a[0]), 32'(vecs[v].e_busy));
      checkOutput($sformatf("vec%0d pc", v),    0, 32'(pc_out_a[0]), 32'(vecs[v].e_pc));
      checkOutput($sformatf("vec%0d addr", v),  0, 32'(addr_a[0]), 32'(vecs[v].e_pc));
      checkOutput($sformatf("vec%0d ir", v),    0, 32'(ir_a[0]), 32'(vecs[v].e_ir));
    end

    // Back-to-back: three fetches from 0x010 with fetch_req held high.
    idleSteps(8);
    applyStimulus(1'b0, 1'b1, 12'h010);
    we_cnt = 0;
    for (int s = 1; s <= 20; s++) begin
      applyStimulus((s <= 12) ? 1'b1 : 1'b0, 1'b0, '0);
      if (rd_a[0]) begin
        rd_cyc.push_back(s);
        rd_addr.push_back(addr_a[0]);
      end
      if (we_a[0]) we_cnt++;
    end
    checkOutput("b2b rd count", 0, 32'(rd_cyc.size()), 32'd3);
    checkOutput("b2b we count", 0, 32'(we_cnt), 32'd3);
    checkOutput("b2b final pc", 0, 32'(pc_out_a[0]), 32'h013);
    if (rd_cyc.size() == 3) begin
      checkOutput("b2b spacing1", 0, 32'(rd_cyc[1] - rd_cyc[0]), 32'd4);
      checkOutput("b2b spacing2", 0, 32'(rd_cyc[2] - rd_cyc[1]), 32'd4);
      for (int k = 0; k < 3; k++)
        checkOutput($sformatf("b2b addr%0d", k), 0, 32'(rd_addr[k]), 32'h010 + 32'(k));
    end

    // A jump presented during ISSUE replaces the increment.
    idleSteps(8);
    applyStimulus(1'b1, 1'b0, '0);
    idleSteps(3);
    checkOutput("issue we", 0, 32'(we_a[0]), 32'd1);
    applyStimulus(1'b0, 1'b1, 12'h200);
    checkOutput("load in issue", 0, 32'(pc_out_a[0]), 32'h200);

    // Load and request while waiting on memory are both dropped.
    idleSteps(8);
    rd_cnt = 0;
    applyStimulus(1'b1, 1'b0, '0);
    if (rd_a[0]) rd_cnt++;
    applyStimulus(1'b0, 1'b0, '0);
    if (rd_a[0]) rd_cnt++;
    applyStimulus(1'b1, 1'b1, 12'h555);
    if (rd_a[0]) rd_cnt++;
    for (int s = 0; s < 8; s++) begin
      applyStimulus(1'b0, 1'b0, '0);
      if (rd_a[0]) rd_cnt++;
    end
    checkOutput("wait ignores req", 0, 32'(rd_cnt), 32'd1);
    checkOutput("wait ignores load", 0, 32'(pc_out_a[0]), 32'h201);

    // Asynchronous reset in the middle of a fetch.
    idleSteps(8);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    #3;
    rst = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      checkOutput("rst pc",    g, 32'(pc_out_a[g]), 32'd0);
      checkOutput("rst addr",  g, 32'(addr_a[g]), 32'd0);
      checkOutput("rst rd_en", g, 32'(rd_a[g]), 32'd0);
      checkOutput("rst we",    g, 32'(we_a[g]), 32'd0);
      checkOutput("rst done",  g, 32'(fd_a[g]), 32'd0);
      checkOutput("rst busy",  g, 32'(busy_a[g]), 32'd0);
      checkOutput("rst ir",    g, 32'(ir_a[g]), 32'd0);
    end
    modelReset();
    @(posedge clk);
    #1;
    checkAgainstModel();
    @(negedge clk);
    rst = 1'b0;
    we_cnt = 0;
    for (int s = 0; s < 8; s++) begin
      applyStimulus(1'b0, 1'b0, '0);
      if (we_a[0]) we_cnt++;
    end
    checkOutput("no we after rst", 0, 32'(we_cnt), 32'd0);
    checkOutput("pc after rst", 0, 32'(pc_out_a[0]), 32'd0);

    // Latency sweep: IR write lands in cycle 2+MEM_LAT after the request edge.
    for (int g = 0; g < 3; g++) begin
      first_we[g] = -1;
      we_hits[g]  = 0;
    end
    applyStimulus(1'b1, 1'b0, '0);
    for (int c = 2; c <= 12; c++) begin
      applyStimulus(1'b0, 1'b0, '0);
      for (int g = 0; g < 3; g++) begin
        if (we_a[g]) begin
          we_hits[g]++;
          if (first_we[g] < 0) first_we[g] = c;
        end
      end
    end
    for (int g = 0; g < 3; g++) begin
      checkOutput("lat we cycle", g, 32'(first_we[g]), 32'(2 + latOf(g)));
      checkOutput("lat we pulses", g, 32'(we_hits[g]), 32'd1);
      checkOutput("lat ir", g, 32'(ir_a[g]), 32'h12ABC);
    end

    // Random traffic against the model.
    for (int s = 0; s < 600; s++) begin
      applyStimulus(($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                    AW'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
